// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write queue and its forwarding search.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  // Writes to this index are architecturally discarded.
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] idx;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_fwd_match.sv
// Youngest-match search over the pending write queue for one operand index.
module regfile_fwd_match
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic [ADDR_W-1:0] lookup,
  input  logic [ADDR_W-1:0] regs  [DEPTH],
  input  logic [DATA_W-1:0] datas [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [CNT_W-1:0]  count,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PTR_W-1:0] slot;

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    slot = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (regs[slot] == lookup) &&
          (lookup != ADDR_W'(REG_ZERO))) begin
        hit  = 1'b1;
        data = datas[slot];
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// Two-lane in-order write buffer in front of the single-port register file,
// draining one entry per cycle and forwarding pending data to RS/RT reads.
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     in_ready,
  input  logic                     in_a_valid,
  input  logic [ADDR_W-1:0]        in_a_reg,
  input  logic [DATA_W-1:0]        in_a_data,
  input  logic                     in_b_valid,
  input  logic [ADDR_W-1:0]        in_b_reg,
  input  logic [DATA_W-1:0]        in_b_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_reg,
  output logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        lookup_rs,
  input  logic [ADDR_W-1:0]        lookup_rt,
  output logic                     fwd_rs_hit,
  output logic [DATA_W-1:0]        fwd_rs_data,
  output logic                     fwd_rt_hit,
  output logic [DATA_W-1:0]        fwd_rt_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] ent_reg_q  [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, b_slot;
  logic [CNT_W-1:0] count_q, count_d, n_acc;
  logic             acc_a, acc_b, pop;

  // Acceptance, slot selection and pointer/occupancy next state.
  always_comb begin
    in_ready = count_q <= CNT_W'(DEPTH - 2);
    acc_a    = in_a_valid && in_ready && (in_a_reg != ADDR_W'(REG_ZERO));
    acc_b    = in_b_valid && in_ready && (in_b_reg != ADDR_W'(REG_ZERO));
    pop      = count_q != '0;
    // B lands behind A only when A actually takes a slot.
    b_slot   = acc_a ? tail_q + PTR_W'(1) : tail_q;
    n_acc    = CNT_W'(acc_a) + CNT_W'(acc_b);
    tail_d   = tail_q + PTR_W'(n_acc);
    head_d   = head_q + PTR_W'(pop);
    count_d  = count_q + n_acc - CNT_W'(pop);
  end

  // Pointer and occupancy state; reset discards everything pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful inside the occupied window.
  always_ff @(posedge clk) begin
    if (acc_a) begin
      ent_reg_q[tail_q]  <= in_a_reg;
      ent_data_q[tail_q] <= in_a_data;
    end
    if (acc_b) begin
      ent_reg_q[b_slot]  <= in_b_reg;
      ent_data_q[b_slot] <= in_b_data;
    end
  end

  // Register file port driven straight from the head entry.
  always_comb begin
    wr_en   = count_q != '0;
    wr_reg  = ent_reg_q[head_q];
    wr_data = ent_data_q[head_q];
    count   = count_q;
    empty   = count_q == '0;
  end

  regfile_fwd_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwd_rs (
    .lookup (lookup_rs),
    .regs   (ent_reg_q),
    .datas  (ent_data_q),
    .head   (head_q),
    .count  (count_q),
    .hit    (fwd_rs_hit),
    .data   (fwd_rs_data)
  );

  regfile_fwd_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwd_rt (
    .lookup (lookup_rt),
    .regs   (ent_reg_q),
    .datas  (ent_data_q),
    .head   (head_q),
    .count  (count_q),
    .hit    (fwd_rt_hit),
    .data   (fwd_rt_data)
  );

endmodule

// File: doc/regfile_write_queue.md
# regfile_write_queue

Write-side front end for the 32×32 MIPS register file. The block accepts up to two register writeback requests per cycle from the execute/memory stages and buffers them in a small in-order queue. It drains one entry per cycle into the register file's single write port. It also forwards still-pending data to the RS/RT operand reads, so the decode stage never reads a stale register.

## Interface
- DEPTH, 4, queue entries; power of two, at least 2
- DATA_W, 32, register data width
- ADDR_W, 5, register index width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_ready  out  1  high when at least 2 entries are free; both lanes may be offered
- in_a_valid  in  1  lane A (older) write request
- in_a_reg  in  ADDR_W  lane A destination register
- in_a_data  in  DATA_W  lane A data
- in_b_valid  in  1  lane B (younger) write request
- in_b_reg  in  ADDR_W  lane B destination register
- in_b_data  in  DATA_W  lane B data
- wr_en  out  1  register file write enable (head entry valid)
- wr_reg  out  ADDR_W  register file write index
- wr_data  out  DATA_W  register file write data
- lookup_rs  in  ADDR_W  RS operand index
- lookup_rt  in  ADDR_W  RT operand index
- fwd_rs_hit  out  1  pending write to lookup_rs exists
- fwd_rs_data  out  DATA_W  newest pending data for lookup_rs; 0 when no hit
- fwd_rt_hit  out  1  same, for RT
- fwd_rt_data  out  DATA_W  same, for RT
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

## Operation
- Storage is a circular buffer of {reg, data} entries with head/tail pointers and an occupancy counter. Pointers wrap modulo DEPTH.
- Enqueue:
  - A lane is accepted when in_x_valid && in_ready && in_x_reg != 0. Writes to $zero are silently dropped and consume no entry.
  - When both lanes are accepted, A is written at tail and B at tail+1. If only one lane is accepted, it takes tail.
  - Offering valid while in_ready is low is a protocol violation. The request is ignored and state is unchanged.
- Drain:
  - wr_en = !empty; wr_reg/wr_data = head entry, all combinational from registered state.
  - The head pops on every edge where wr_en is high. The register file is assumed always ready.
- Forwarding:
  - Combinational search over all valid entries, including the head.
  - On a match, the youngest entry wins (closest to tail).
  - Index 0 never hits.
  - Entries being enqueued in the current cycle are not searched. The producer bypasses its own result.
- Same register in both lanes: both are stored. A drains before B, and lookup returns B's data.
- count_next = count + accepted_lanes − (wr_en ? 1 : 0).
- in_ready = (DEPTH − count) ≥ 2, computed from registered count only. It is conservative and ignores the same-cycle pop.

## Timing
- Reset (asynchronous assert, synchronous release):
  - head, tail and count are 0; empty = 1; in_ready = 1; wr_en = 0.
  - fwd_*_hit = 0 and fwd_*_data = 0.
  - Entry contents are don't-care.
- Reset mid-operation discards all pending writes. No wr_en pulse occurs during or after reset until a new enqueue.
- Latency: a write accepted at edge N appears on wr_en during cycle N+1 at the earliest and is committed to the register file at edge N+1.
- It is visible on fwd_* from cycle N+1 until the edge on which it pops.
- Throughput: sustained 1 write/cycle drain. Bursts of 2/cycle are absorbed up to DEPTH entries.
- Full (count = DEPTH): in_ready = 0 and the drain continues. in_ready returns once count ≤ DEPTH−2.

## Structure
- Shared package regfile_pkg holds:
  - REG_ZERO = 5'd0, DATA_W and ADDR_W defaults;
  - typedef wb_entry_t {reg, data}.
- One sub-module, regfile_fwd_match: a priority youngest-match search over the queue for one lookup index, returning hit and data. It is instantiated twice, for RS and RT.

## Test plan
- Reset then enqueue A=(r3, 0x11): wr_en=1, wr_reg=3, wr_data=0x11 the next cycle; fwd_rs_hit=1 with lookup_rs=3 during that cycle; empty=1 after.
- Both lanes (r5, 0xA) and (r5, 0xB) in one cycle: lookup r5 returns 0xB; drain order is 0xA then 0xB on consecutive cycles.
- Lane A targets r0 and lane B targets r7: only r7 is queued (count=1); lookup r0 never hits.
- Offer 2 writes/cycle for 4 cycles with DEPTH=4: in_ready drops when count > 2; no entry is lost; drain order matches enqueue order across pointer wrap.
- Assert rst_n low with 3 pending entries: wr_en=0 and count=0 immediately (asynchronously); no stale write after release.
- Enqueue r9 and look up r9 in the same cycle: hit=0; hit=1 next cycle.
